instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 141 ++++++++++++++
 tb/tb_instruction_fetch.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// instruction_fetch: single-outstanding instruction fetch unit.
// Issues one memory request at the PC. It captures the returned word and holds it
// for decode until decode accepts it, then loads the next PC supplied by decode.
// Optional feature: define ALIGN_CHECK_EN to trap a misaligned next PC into a
// sticky FAULT state that only reset clears.
module instruction_fetch #(
   parameter logic [63:0] RESET_PC = 64'h0
) (
   input  logic        CLK,
   input  logic        Reset,
   input  logic [63:0] NextPC,
   input  logic        InstrReady,
   input  logic        ImemGnt,
   input  logic        ImemRvalid,
   input  logic [31:0] ImemRdata,
   output logic        ImemReq,
   output logic [63:0] ImemAddr,
   output logic [63:0] CurrentPC,
   output logic [31:0] Instruction,
   output logic        InstrValid,
   output logic [31:0] FetchCount,
   output logic        Fault
);

   localparam int unsigned XLEN = 64;
   localparam int unsigned ILEN = 32;
   localparam int unsigned CW   = 32;

   typedef enum logic [1:0] {
      S_REQ   = 2'd0,
      S_WAIT  = 2'd1,
      S_HOLD  = 2'd2,
      S_FAULT = 2'd3
   } state_t;

   state_t            state_q;
   state_t            state_d;
   logic              capture;
   logic              accept;
   logic [XLEN-1:0]   pc_q;

   // The PC register drives both the memory address and the decode-side PC
   assign ImemAddr  = pc_q;
   assign CurrentPC = pc_q;

   // Next-state decode; capture/accept strobes qualify the datapath updates
   always_comb begin
      state_d = state_q;
      capture = 1'b0;
      accept  = 1'b0;
      case (state_q)
         S_REQ: begin
            if (ImemGnt) begin
               if (ImemRvalid) begin
                  capture = 1'b1;
                  state_d = S_HOLD;
               end else begin
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (ImemRvalid) begin
               capture = 1'b1;
               state_d = S_HOLD;
            end
         end
         S_HOLD: begin
            if (InstrReady) begin
               accept  = 1'b1;
               state_d = S_REQ;
`ifdef ALIGN_CHECK_EN
               if (NextPC[1:0] != 2'b00) begin
                  state_d = S_FAULT;
               end
`endif
            end
         end
         S_FAULT: begin
            state_d = S_FAULT;
         end
         default: begin
            state_d = S_REQ;
         end
      endcase
   end

   // State register with registered request/valid flags decoded from the next state
   always_ff @(posedge CLK) begin
      if (Reset) begin
         state_q    <= S_REQ;
         ImemReq    <= 1'b1;
         InstrValid <= 1'b0;
      end else begin
         state_q    <= state_d;
         ImemReq    <= (state_d == S_REQ);
         InstrValid <= (state_d == S_HOLD);
      end
   end

   // Instruction capture: only on a qualified response, so stray rvalids are dropped
   always_ff @(posedge CLK) begin
      if (Reset) begin
         Instruction <= ILEN'(0);
      end else if (capture) begin
         Instruction <= ImemRdata;
      end
   end

   // PC register: changes only when decode accepts the held instruction
   always_ff @(posedge CLK) begin
      if (Reset) begin
         pc_q <= RESET_PC;
      end else if (accept) begin
         pc_q <= NextPC;
      end
   end

   // Accepted-instruction counter, wraps naturally at 2^32
   always_ff @(posedge CLK) begin
      if (Reset) begin
         FetchCount <= CW'(0);
      end else if (accept) begin
         FetchCount <= FetchCount + CW'(1);
      end
   end

`ifdef ALIGN_CHECK_EN
   // Fault flag mirrors entry into the sticky FAULT state
   always_ff @(posedge CLK) begin
      if (Reset) begin
         Fault <= 1'b0;
      end else begin
         Fault <= (state_d == S_FAULT);
      end
   end
`else
   assign Fault = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed scenarios plus randomized memory/decode traffic.
// Expected fetches are queued as they are issued and checked by a monitor on accept.
module tb_instruction_fetch;

   localparam logic [63:0] RST_PC = 64'h100;

   logic        CLK;
   logic        Reset;
   logic [63:0] NextPC;
   logic        InstrReady;
   logic        ImemGnt;
   logic        ImemRvalid;
   logic [31:0] ImemRdata;
   logic        ImemReq;
   logic [63:0] ImemAddr;
   logic [63:0] CurrentPC;
   logic [31:0] Instruction;
   logic        InstrValid;
   logic [31:0] FetchCount;
   logic        Fault;

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] instr;
      logic [31:0] cnt;
   } exp_t;

   exp_t exp_q[$];
   int   tests  = 0;
   int   errors = 0;

   instruction_fetch #(.RESET_PC(RST_PC)) dut (
      .CLK        (CLK),
      .Reset      (Reset),
      .NextPC     (NextPC),
      .InstrReady (InstrReady),
      .ImemGnt    (ImemGnt),
      .ImemRvalid (ImemRvalid),
      .ImemRdata  (ImemRdata),
      .ImemReq    (ImemReq),
      .ImemAddr   (ImemAddr),
      .CurrentPC  (CurrentPC),
      .Instruction(Instruction),
      .InstrValid (InstrValid),
      .FetchCount (FetchCount),
      .Fault      (Fault)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Memory contents as a pure function of the address
   function automatic logic [31:0] mem_word(input logic [63:0] a);
      logic [31:0] w;
      w = (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0F0F;
      return w;
   endfunction

   // Scoreboard monitor: every decode accept must match the oldest expected fetch
   always @(negedge CLK) begin
      exp_t e;
      if (!Reset && InstrValid && InstrReady) begin
         if (exp_q.size() == 0) begin
            check("sb_unexpected_accept", 64'(CurrentPC), 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            check("sb_pc",    CurrentPC,          e.pc);
            check("sb_instr", 64'(Instruction),   64'(e.instr));
            check("sb_count", 64'(FetchCount),    64'(e.cnt));
         end
      end
   end

   // Absolute time bound
   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1, "timeout");
   end

   logic [63:0] model_pc;
   logic [31:0] model_count;
   logic        pending;
   logic [63:0] nxt;
   int          accepts;

   initial begin
      Reset = 1'b1; NextPC = 64'h0; InstrReady = 1'b0;
      ImemGnt = 1'b0; ImemRvalid = 1'b0; ImemRdata = 32'h0;

      // Reset state
      step(); step();
      Reset = 1'b0;
      check("rst_req",   64'(ImemReq),     64'd1);
      check("rst_addr",  ImemAddr,         RST_PC);
      check("rst_valid", 64'(InstrValid),  64'd0);
      check("rst_count", 64'(FetchCount),  64'd0);
      check("rst_fault", 64'(Fault),       64'd0);
      check("rst_instr", 64'(Instruction), 64'd0);

      // Grant and respond in the request cycle
      ImemGnt = 1'b1; ImemRvalid = 1'b1; ImemRdata = 32'hF840_0000;
      exp_q.push_back('{pc: RST_PC, instr: 32'hF840_0000, cnt: 32'd0});
      step();
      check("fast_valid", 64'(InstrValid),  64'd1);
      check("fast_instr", 64'(Instruction), 64'hF840_0000);
      check("fast_pc",    CurrentPC,        RST_PC);
      check("fast_noreq", 64'(ImemReq),     64'd0);

      // Stray rvalid while holding is ignored
      ImemGnt = 1'b0; ImemRvalid = 1'b1; ImemRdata = 32'hDEAD_BEEF;
      step();
      check("spur_instr", 64'(Instruction), 64'hF840_0000);
      check("spur_valid", 64'(InstrValid),  64'd1);

      // Branch accept
      ImemRvalid = 1'b0; InstrReady = 1'b1; NextPC = 64'h10C;
      step();
      InstrReady = 1'b0;
      check("br_addr",  ImemAddr,        64'h10C);
      check("br_req",   64'(ImemReq),    64'd1);
      check("br_count", 64'(FetchCount), 64'd1);
      check("br_valid", 64'(InstrValid), 64'd0);

      // Grant without data, then slow response; ready ignored while waiting
      ImemGnt = 1'b1;
      step();
      check("wait_req",   64'(ImemReq),    64'd0);
      check("wait_valid", 64'(InstrValid), 64'd0);
      ImemGnt = 1'b0; InstrReady = 1'b1; NextPC = 64'hBAD0;
      for (int i = 0; i < 2; i++) begin
         step();
         check("wait_addr",  ImemAddr,        64'h10C);
         check("wait_count", 64'(FetchCount), 64'd1);
         check("wait_nv",    64'(InstrValid), 64'd0);
      end
      InstrReady = 1'b0; ImemRvalid = 1'b1; ImemRdata = 32'h1234_5678;
      exp_q.push_back('{pc: 64'h10C, instr: 32'h1234_5678, cnt: 32'd1});
      step();
      ImemGnt = 1'b1; ImemRdata = 32'hFFFF_0000;
      for (int i = 0; i < 4; i++) begin
         check("hold_instr", 64'(Instruction), 64'h1234_5678);
         check("hold_pc",    CurrentPC,        64'h10C);
         step();
      end
      check("hold_instr_end", 64'(Instruction), 64'h1234_5678);
      ImemGnt = 1'b0; ImemRvalid = 1'b0; InstrReady = 1'b1; NextPC = 64'h110;
      step();
      InstrReady = 1'b0;
      check("seq_addr",  ImemAddr,        64'h110);
      check("seq_count", 64'(FetchCount), 64'd2);

      // Reset in WAIT, then late rvalid without grant
      ImemGnt = 1'b1;
      step();
      check("w2_req", 64'(ImemReq), 64'd0);
      ImemGnt = 1'b0; Reset = 1'b1;
      step();
      Reset = 1'b0; ImemRvalid = 1'b1; ImemRdata = 32'hCAFE_F00D;
      check("wrst_req",   64'(ImemReq),    64'd1);
      check("wrst_addr",  ImemAddr,        RST_PC);
      check("wrst_count", 64'(FetchCount), 64'd0);
      check("wrst_valid", 64'(InstrValid), 64'd0);
      step();
      ImemRvalid = 1'b0;
      check("late_req",   64'(ImemReq),     64'd1);
      check("late_valid", 64'(InstrValid),  64'd0);
      check("late_instr", 64'(Instruction), 64'd0);

      // Counter wrap
      force dut.FetchCount = 32'hFFFF_FFFF;
      #1;
      release dut.FetchCount;
      check("wrap_pre", 64'(FetchCount), 64'hFFFF_FFFF);
      ImemGnt = 1'b1; ImemRvalid = 1'b1; ImemRdata = 32'h0BAD_C0DE;
      exp_q.push_back('{pc: RST_PC, instr: 32'h0BAD_C0DE, cnt: 32'hFFFF_FFFF});
      step();
      ImemGnt = 1'b0; ImemRvalid = 1'b0; InstrReady = 1'b1; NextPC = 64'h200;
      step();
      InstrReady = 1'b0;
      check("wrap_count", 64'(FetchCount), 64'd0);
      check("wrap_addr",  ImemAddr,        64'h200);

      // Misaligned next PC
      ImemGnt = 1'b1; ImemRvalid = 1'b1; ImemRdata = 32'h1111_1111;
      exp_q.push_back('{pc: 64'h200, instr: 32'h1111_1111, cnt: 32'd0});
      step();
      ImemGnt = 1'b0; ImemRvalid = 1'b0; InstrReady = 1'b1; NextPC = 64'h102;
      step();
      InstrReady = 1'b0;
      check("mis_addr",  ImemAddr,        64'h102);
      check("mis_count", 64'(FetchCount), 64'd1);
`ifdef ALIGN_CHECK_EN
      ImemGnt = 1'b1; ImemRvalid = 1'b1; InstrReady = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check("flt_fault", 64'(Fault),      64'd1);
         check("flt_req",   64'(ImemReq),    64'd0);
         check("flt_valid", 64'(InstrValid), 64'd0);
         check("flt_addr",  ImemAddr,        64'h102);
         step();
      end
      ImemGnt = 1'b0; ImemRvalid = 1'b0; InstrReady = 1'b0;
`else
      check("mis_fault", 64'(Fault),   64'd0);
      check("mis_req",   64'(ImemReq), 64'd1);
`endif

      // Randomized traffic against the fetch-sequence model
      Reset = 1'b1;
      step();
      Reset = 1'b0;
      check("sb_empty_dir", 64'(exp_q.size()), 64'd0);
      model_pc    = RST_PC;
      model_count = 32'd0;
      pending     = 1'b0;
      accepts     = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         ImemGnt    = 1'b0;
         ImemRvalid = 1'b0;
         ImemRdata  = $urandom;
         InstrReady = 1'($urandom);
         NextPC     = {$urandom, $urandom};
         if (ImemReq) begin
            check("rnd_addr", ImemAddr, model_pc);
            ImemGnt = ($urandom % 3) != 0;
            if (ImemGnt) begin
               if (($urandom % 2) != 0) begin
                  ImemRvalid = 1'b1;
                  ImemRdata  = mem_word(ImemAddr);
                  exp_q.push_back('{pc: model_pc, instr: mem_word(model_pc), cnt: model_count});
               end else begin
                  pending = 1'b1;
               end
            end else begin
               ImemRvalid = ($urandom % 4) == 0;
            end
         end else if (pending) begin
            if (($urandom % 3) == 0) begin
               ImemRvalid = 1'b1;
               ImemRdata  = mem_word(ImemAddr);
               exp_q.push_back('{pc: model_pc, instr: mem_word(model_pc), cnt: model_count});
               pending = 1'b0;
            end
         end else if (InstrValid) begin
            ImemRvalid = ($urandom % 4) == 0;
            ImemGnt    = ($urandom % 4) == 0;
            if (InstrReady) begin
               case ($urandom % 4)
                  0, 1:    nxt = model_pc + 64'd4;
                  2:       nxt = model_pc + 64'(($urandom % 64) << 2) - 64'd128;
                  default: nxt = {$urandom, $urandom} & ~64'h3;
               endcase
`ifndef ALIGN_CHECK_EN
               if (($urandom % 8) == 0) nxt[1:0] = 2'($urandom);
`endif
               NextPC      = nxt;
               model_pc    = nxt;
               model_count = model_count + 32'd1;
               accepts++;
            end
         end else begin
            check("rnd_stuck", 64'({ImemReq, InstrValid}), 64'd1);
         end
         step();
      end
      ImemGnt = 1'b0; ImemRvalid = 1'b0; InstrReady = 1'b0;
      step();
      check("rnd_progress", 64'(accepts > 300), 64'd1);
      check("rnd_count",    64'(FetchCount),    64'(model_count));
      check("rnd_sb_left",  64'(exp_q.size() <= 1), 64'd1);

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
